// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
//   state_e       : controller states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand/result width
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_if.sv
// Controller-side handshake and data bus of the bit-serial adder.
//   start/a_in/b_in/cin       : request and operands (controller -> adder)
//   busy/done/sum_out/cout/overflow : status and result (adder -> controller)
// Modports: master = controller, slave = adder.
interface serial_adder_if #(
    parameter int unsigned WIDTH = serial_adder_pkg::DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a_in, b_in, cin,
        input  busy, done, sum_out, cout, overflow
    );

    modport slave (
        input  start, a_in, b_in, cin,
        output busy, done, sum_out, cout, overflow
    );

endinterface : serial_adder_if

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit combinational full adder used by the serial datapath.
//   a, b, c : addend bits and carry-in
//   sum     : a ^ b ^ c
//   carry   : majority(a, b, c)
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (b & c) | (a & c);

endmodule : full_adder_cell

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB first, one bit per clock,
// through a single full-adder cell with a registered carry.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of serial_adder_if (start/operands in, busy/done/result out)
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);

    localparam int unsigned     CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_q,    state_d;
    logic [WIDTH-1:0]   a_sr_q,     a_sr_d;
    logic [WIDTH-1:0]   b_sr_q,     b_sr_d;
    logic [WIDTH-1:0]   res_sr_q,   res_sr_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               carry_q,    carry_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic [WIDTH-1:0]   sum_q,      sum_d;
    logic               cout_q,     cout_d;
    logic               ovf_q,      ovf_d;

    logic               cell_sum;
    logic               cell_carry;
    logic [WIDTH-1:0]   res_next_c;

    full_adder_cell u_cell (
        .a     (a_sr_q[0]),
        .b     (b_sr_q[0]),
        .c     (carry_q),
        .sum   (cell_sum),
        .carry (cell_carry)
    );

    // New sum bit enters at the MSB so the LSB-first stream ends up in place.
    assign res_next_c = {cell_sum, res_sr_q[WIDTH-1:1]};

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    a_sr_d   = bus.a_in;
                    b_sr_d   = bus.b_in;
                    carry_d  = bus.cin;
                    cnt_d    = '0;
                    res_sr_d = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end

            RUN: begin
                carry_d  = cell_carry;
                res_sr_d = res_next_c;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // carry_q here is the carry into the MSB.
                    sum_d   = res_next_c;
                    cout_d  = cell_carry;
                    ovf_d   = carry_q ^ cell_carry;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum_out  = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH = 8): directed corner cases plus
// randomized operations against an arithmetic reference model.
module tb_serial_adder;
    import serial_adder_pkg::*;

    localparam int unsigned W = DEFAULT_WIDTH;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Last completed result, expected to be held on the outputs during RUN.
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    logic         prev_ovf;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation from the current cycle (IDLE or DONE) and check it.
    // inject_cyc > 0 re-pulses start with other operands during that RUN cycle.
    // b2b_next leaves the bench in the DONE cycle so the next call starts back-to-back.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input int inject_cyc, input bit b2b_next, input string tag);
        logic [W:0]   full;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
        int           cyc;
        int           nbusy;

        full     = {1'b0, a} + {1'b0, b} + (W+1)'(c);
        exp_sum  = full[W-1:0];
        exp_cout = full[W];
        exp_ovf  = (a[W-1] == b[W-1]) && (exp_sum[W-1] != a[W-1]);

        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.cin   = c;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a_in  = W'($urandom);
        bus.b_in  = W'($urandom);
        bus.cin   = 1'($urandom);

        cyc   = 1;
        nbusy = 0;
        while (bus.done !== 1'b1 && cyc <= 4 * W) begin
            if (bus.busy === 1'b1) nbusy++;
            if (cyc == 4) begin
                check_eq({tag, "/hold_sum"},  32'(bus.sum_out),  32'(prev_sum));
                check_eq({tag, "/hold_cout"}, 32'(bus.cout),     32'(prev_cout));
                check_eq({tag, "/hold_ovf"},  32'(bus.overflow), 32'(prev_ovf));
            end
            if (cyc == inject_cyc) begin
                bus.start = 1'b1;
                bus.a_in  = W'(32'h11);
                bus.b_in  = W'(32'h22);
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;

        check_eq({tag, "/latency"},      32'(cyc - 1),      32'(W));
        check_eq({tag, "/busy_cycles"},  32'(nbusy),        32'(W));
        check_eq({tag, "/busy_at_done"}, 32'(bus.busy),     32'(0));
        check_eq({tag, "/sum"},          32'(bus.sum_out),  32'(exp_sum));
        check_eq({tag, "/cout"},         32'(bus.cout),     32'(exp_cout));
        check_eq({tag, "/overflow"},     32'(bus.overflow), 32'(exp_ovf));

        prev_sum  = exp_sum;
        prev_cout = exp_cout;
        prev_ovf  = exp_ovf;

        if (!b2b_next) begin
            @(posedge clk); #1;
            check_eq({tag, "/done_pulse"}, 32'(bus.done), 32'(0));
        end
    endtask

    initial begin
        bit seen_done;
        bit b2b;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        bus.cin   = 1'b0;
        prev_sum  = '0;
        prev_cout = 1'b0;
        prev_ovf  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset/busy",     32'(bus.busy),     32'(0));
        check_eq("reset/done",     32'(bus.done),     32'(0));
        check_eq("reset/sum",      32'(bus.sum_out),  32'(0));
        check_eq("reset/cout",     32'(bus.cout),     32'(0));
        check_eq("reset/overflow", 32'(bus.overflow), 32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(W'(32'h05), W'(32'h03), 1'b0, 0, 1'b0, "basic");
        run_op(W'(32'hFF), W'(32'h01), 1'b0, 0, 1'b0, "carry_ff_01");
        run_op(W'(32'hFF), W'(32'h00), 1'b1, 0, 1'b0, "carry_ff_cin");
        run_op(W'(32'h7F), W'(32'h01), 1'b0, 0, 1'b0, "ovf_7f_01");
        run_op(W'(32'h80), W'(32'h80), 1'b0, 0, 1'b0, "ovf_80_80");
        run_op(W'(32'h05), W'(32'h03), 1'b0, 3, 1'b0, "start_ignored");
        run_op(W'(32'h0F), W'(32'h01), 1'b0, 0, 1'b1, "pre_b2b");
        run_op(W'(32'h10), W'(32'h20), 1'b0, 0, 1'b0, "b2b");

        // Reset during RUN: operation discarded, no done, outputs cleared.
        bus.start = 1'b1;
        bus.a_in  = W'(32'hAA);
        bus.b_in  = W'(32'h55);
        bus.cin   = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("midrst/busy",     32'(bus.busy),     32'(0));
        check_eq("midrst/done",     32'(bus.done),     32'(0));
        check_eq("midrst/sum",      32'(bus.sum_out),  32'(0));
        check_eq("midrst/cout",     32'(bus.cout),     32'(0));
        check_eq("midrst/overflow", 32'(bus.overflow), 32'(0));
        seen_done = 1'b0;
        repeat (W + 2) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        check_eq("midrst/no_done", 32'(seen_done), 32'(0));
        prev_sum  = '0;
        prev_cout = 1'b0;
        prev_ovf  = 1'b0;
        run_op(W'(32'h01), W'(32'h01), 1'b0, 0, 1'b0, "after_reset");

        // Randomized operations with random gaps and back-to-back starts.
        for (int i = 0; i < 20; i++) begin
            b2b = (i != 19) && ($urandom_range(0, 1) == 1);
            run_op(W'($urandom), W'($urandom), 1'($urandom), 0, b2b, "random");
            if (!b2b) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_serial_adder
